// File: rtl/snac_pkg.sv
// Shared constants and state encodings for the SNAC controller-side transmitter.
package snac_pkg;
  localparam int PIN_R  = 2;
  localparam int PIN_L  = 1;
  localparam int PIN_D  = 7;
  localparam int PIN_U  = 5;
  localparam int PIN_F  = 3;
  localparam int PIN_P0 = 1;
  localparam int PIN_P1 = 2;
  localparam int NUM_PAD = 2;

  typedef enum logic {SETTLE, DRIVE} top_st_e;
  typedef enum logic [1:0] {DUMP, COUNT, FIRE} pad_st_e;
endpackage

// File: rtl/snac_paddle_timer.sv
// One paddle pin: synchronizes the host dump sense and emulates the pot charge time.
module snac_paddle_timer
  import snac_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PAD_UNIT    = 64,
  parameter int PAD_BITS    = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                dump_in,
  input  logic                sel,
  input  logic [PAD_BITS-1:0] pos_a,
  input  logic [PAD_BITS-1:0] pos_b,
  output logic                out
);
  localparam int CW = PAD_BITS + $clog2(PAD_UNIT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dump_sync, dump_q, rise, fall;
  pad_st_e                st, st_n;
  logic [CW-1:0]          cnt, cnt_n;

  assign dump_sync = sync[SYNC_STAGES-1];
  assign rise      = dump_sync & ~dump_q;
  assign fall      = ~dump_sync & dump_q;
  assign out       = (st == FIRE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync   <= '1;
      dump_q <= 1'b1;
      st     <= DUMP;
      cnt    <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], dump_in};
      dump_q <= dump_sync;
      st     <= st_n;
      cnt    <= cnt_n;
    end
  end

  // Expiry is tested on the value being decremented to zero, so a zero
  // position still spends one cycle in COUNT.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    case (st)
      DUMP: if (fall) begin
        cnt_n = CW'(sel ? pos_a : pos_b) * CW'(PAD_UNIT);
        st_n  = COUNT;
      end
      COUNT: begin
        if (rise) st_n = DUMP;
        else if (cnt <= CW'(1)) begin
          st_n  = FIRE;
          cnt_n = '0;
        end else cnt_n = cnt - CW'(1);
      end
      FIRE:    if (rise) st_n = DUMP;
      default: st_n = DUMP;
    endcase
  end
endmodule

// File: rtl/snac_ctrl_tx.sv
// SNAC user-port transmitter: drives the selected player's joystick or paddle
// state onto the open-drain pins, with a release window around select/mode changes.
module snac_ctrl_tx
  import snac_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int PAD_UNIT    = 64,
  parameter int PAD_BITS    = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  sel_in,
  input  logic [1:0]            dump_in,
  input  logic                  pad_mode,
  input  logic [4:0]            joy_a,
  input  logic [4:0]            joy_b,
  input  logic [2*PAD_BITS-1:0] pad_a,
  input  logic [2*PAD_BITS-1:0] pad_b,
  output logic [7:0]            user_out,
  output logic                  sel_sync,
  output logic                  driving
);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  logic [SYNC_STAGES-1:0]            sel_sr;
  logic                              sel_q, mode_q, mode_d, chg;
  top_st_e                           st, st_n;
  logic [SW-1:0]                     scnt, scnt_n;
  logic [4:0]                        joy;
  logic [7:0]                        pins, uo_n;
  logic [NUM_PAD-1:0]                tmr;
  logic [NUM_PAD-1:0][PAD_BITS-1:0]  pa, pb;

  assign sel_sync = sel_sr[SYNC_STAGES-1];
  assign driving  = (st == DRIVE);
  assign pa       = pad_a;
  assign pb       = pad_b;

  for (genvar i = 0; i < NUM_PAD; i++) begin : g_pad
    snac_paddle_timer #(
      .SYNC_STAGES(SYNC_STAGES), .PAD_UNIT(PAD_UNIT), .PAD_BITS(PAD_BITS)
    ) u_tmr (
      .clk_sys(clk_sys), .reset(reset), .dump_in(dump_in[i]), .sel(sel_sync),
      .pos_a(pa[i]), .pos_b(pb[i]), .out(tmr[i])
    );
  end

  always_comb begin
    joy  = sel_sync ? joy_a : joy_b;
    pins = '1;
    if (!mode_q) begin
      pins[PIN_R] = ~joy[0];
      pins[PIN_L] = ~joy[1];
      pins[PIN_D] = ~joy[2];
      pins[PIN_U] = ~joy[3];
      pins[PIN_F] = ~joy[4];
    end else begin
      pins[PIN_P0] = tmr[0];
      pins[PIN_P1] = tmr[1];
      pins[PIN_F]  = ~joy[4];
      pins[PIN_D]  = ~joy[2];
    end
  end

  assign chg = (sel_sync ^ sel_q) | (mode_q ^ mode_d);

  always_comb begin
    st_n   = st;
    scnt_n = scnt;
    if (chg) begin
      st_n   = SETTLE;
      scnt_n = SW'(SETTLE_CYC - 1);
    end else begin
      case (st)
        SETTLE:  if (scnt == '0) st_n = DRIVE; else scnt_n = scnt - SW'(1);
        default: st_n = DRIVE;
      endcase
    end
    // Decide on the next state so the release window is exactly SETTLE_CYC cycles.
    uo_n = (st_n == DRIVE) ? pins : 8'hFF;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sel_sr   <= '1;
      sel_q    <= 1'b1;
      mode_q   <= 1'b0;
      mode_d   <= 1'b0;
      st       <= SETTLE;
      scnt     <= SW'(SETTLE_CYC - 1);
      user_out <= 8'hFF;
    end else begin
      sel_sr   <= {sel_sr[SYNC_STAGES-2:0], sel_in};
      sel_q    <= sel_sync;
      mode_q   <= pad_mode;
      mode_d   <= mode_q;
      st       <= st_n;
      scnt     <= scnt_n;
      user_out <= uo_n;
    end
  end
endmodule
